// File: rtl/b_resp_route_ctrl.sv
// Write-response router: tracks AW owner order, routes slave B channel to the owning master.
// Optional macro BRESP_ERR_CNT_EN adds a saturating error-response counter (err_cnt).
module b_resp_route_ctrl #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             aw_push,
  input  logic             aw_master,
  output logic             aw_full,
  input  logic             M_AXI_bvalid,
  input  logic [1:0]       M_AXI_bresp,
  input  logic             M_AXI_bready,
  output logic             Selected_Slave,
  output logic             S00_AXI_bvalid,
  output logic [1:0]       S00_AXI_bresp,
  output logic             S01_AXI_bvalid,
  output logic [1:0]       S01_AXI_bresp,
  output logic [CNT_W-1:0] outstanding,
`ifdef BRESP_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             unexpected_b,
  output logic             push_ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unexp_q, unexp_d, ovf_q, ovf_d;
  logic             empty, full, pop, push;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign pop   = M_AXI_bvalid && M_AXI_bready && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign push  = aw_push && (!full || pop);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = aw_master;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unexp_d = unexp_q | (M_AXI_bvalid && empty);
    ovf_d   = ovf_q | (aw_push && full && !pop);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      unexp_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      unexp_q  <= unexp_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Selected_Slave = empty ? 1'b0 : fifo_q[rd_ptr_q];
  assign S00_AXI_bvalid = M_AXI_bvalid && !empty && !Selected_Slave;
  assign S01_AXI_bvalid = M_AXI_bvalid && !empty && Selected_Slave;
  assign S00_AXI_bresp  = !Selected_Slave ? M_AXI_bresp : 2'b00;
  assign S01_AXI_bresp  = Selected_Slave ? M_AXI_bresp : 2'b00;
  assign aw_full        = full;
  assign outstanding    = cnt_q;
  assign unexpected_b   = unexp_q;
  assign push_ovf       = ovf_q;

`ifdef BRESP_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts SLVERR/DECERR completions, holding at the top value.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && M_AXI_bresp[1] && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_b_resp_route_ctrl.sv
// Bench for b_resp_route_ctrl: vector table with hand-derived expectations plus an owner-order scoreboard.
module tb_b_resp_route_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic             aw_push, aw_master, aw_full;
  logic             M_AXI_bvalid, M_AXI_bready;
  logic [1:0]       M_AXI_bresp;
  logic             Selected_Slave;
  logic             S00_AXI_bvalid, S01_AXI_bvalid;
  logic [1:0]       S00_AXI_bresp, S01_AXI_bresp;
  logic [CNT_W-1:0] outstanding;
  logic             unexpected_b, push_ovf;
`ifdef BRESP_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  b_resp_route_ctrl #(.DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .aw_push(aw_push), .aw_master(aw_master), .aw_full(aw_full),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bready(M_AXI_bready),
    .Selected_Slave(Selected_Slave),
    .S00_AXI_bvalid(S00_AXI_bvalid), .S00_AXI_bresp(S00_AXI_bresp),
    .S01_AXI_bvalid(S01_AXI_bvalid), .S01_AXI_bresp(S01_AXI_bresp),
    .outstanding(outstanding),
`ifdef BRESP_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .unexpected_b(unexpected_b), .push_ovf(push_ovf)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       p, m, bv;
    logic [1:0] br;
    logic       rdy;
    logic       sel, s0v, s1v;
    logic [1:0] s0r, s1r;
    logic       full;
    logic [2:0] out;    // outstanding after the edge
    logic [1:0] flags;  // {unexpected_b, push_ovf} after the edge
  } vec_t;

  vec_t vecs[20];
  logic sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then runs the scoreboard.
  task automatic drive(input logic p, input logic m, input logic bv, input logic [1:0] br, input logic rdy);
    logic pop_m, acc, owner;
    @(negedge ACLK);
    aw_push = p; aw_master = m; M_AXI_bvalid = bv; M_AXI_bresp = br; M_AXI_bready = rdy;
    #1;
    pop_m = bv && rdy && (sb_q.size() > 0);
    acc   = p && ((sb_q.size() < DEPTH) || pop_m);
    if (pop_m) begin
      owner = sb_q.pop_front();
      chk("sb_route_vld", {30'd0, S01_AXI_bvalid, S00_AXI_bvalid}, owner ? 32'd2 : 32'd1);
      chk("sb_route_resp", {30'd0, owner ? S01_AXI_bresp : S00_AXI_bresp}, {30'd0, br});
    end
    if (acc) sb_q.push_back(m);
  endtask

  initial begin
    ARESET = 1'b1;
    aw_push = 0; aw_master = 0; M_AXI_bvalid = 0; M_AXI_bresp = 2'b00; M_AXI_bready = 0;

    //          p  m  bv br     rdy sel s0v s1v s0r    s1r    full out   flags
    vecs[0]  = '{1, 1, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 0,   3'd1, 2'b00};
    vecs[1]  = '{1, 0, 0, 2'b00, 0,  1,  0,  0,  2'b00, 2'b00, 0,   3'd2, 2'b00};
    vecs[2]  = '{1, 1, 0, 2'b00, 0,  1,  0,  0,  2'b00, 2'b00, 0,   3'd3, 2'b00};
    vecs[3]  = '{0, 0, 1, 2'b00, 1,  1,  0,  1,  2'b00, 2'b00, 0,   3'd2, 2'b00};
    vecs[4]  = '{0, 0, 1, 2'b10, 1,  0,  1,  0,  2'b10, 2'b00, 0,   3'd1, 2'b00};
    vecs[5]  = '{0, 0, 1, 2'b00, 1,  1,  0,  1,  2'b00, 2'b00, 0,   3'd0, 2'b00};
    vecs[6]  = '{0, 0, 1, 2'b00, 1,  0,  0,  0,  2'b00, 2'b00, 0,   3'd0, 2'b10};
    vecs[7]  = '{1, 0, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 0,   3'd1, 2'b10};
    vecs[8]  = '{1, 1, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 0,   3'd2, 2'b10};
    vecs[9]  = '{1, 0, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 0,   3'd3, 2'b10};
    vecs[10] = '{1, 1, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 0,   3'd4, 2'b10};
    vecs[11] = '{1, 0, 0, 2'b00, 0,  0,  0,  0,  2'b00, 2'b00, 1,   3'd4, 2'b11};
    vecs[12] = '{1, 1, 1, 2'b01, 1,  0,  1,  0,  2'b01, 2'b00, 1,   3'd4, 2'b11};
    vecs[13] = '{0, 0, 1, 2'b11, 0,  1,  0,  1,  2'b00, 2'b11, 1,   3'd4, 2'b11};
    vecs[14] = '{0, 0, 1, 2'b11, 0,  1,  0,  1,  2'b00, 2'b11, 1,   3'd4, 2'b11};
    vecs[15] = '{0, 0, 1, 2'b11, 0,  1,  0,  1,  2'b00, 2'b11, 1,   3'd4, 2'b11};
    vecs[16] = '{0, 0, 1, 2'b11, 1,  1,  0,  1,  2'b00, 2'b11, 1,   3'd3, 2'b11};
    vecs[17] = '{0, 0, 1, 2'b00, 1,  0,  1,  0,  2'b00, 2'b00, 0,   3'd2, 2'b11};
    vecs[18] = '{0, 0, 1, 2'b00, 1,  1,  0,  1,  2'b00, 2'b00, 0,   3'd1, 2'b11};
    vecs[19] = '{0, 0, 1, 2'b00, 1,  1,  0,  1,  2'b00, 2'b00, 0,   3'd0, 2'b11};

    // Power-on reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_comb", {24'd0, Selected_Slave, S00_AXI_bvalid, S01_AXI_bvalid, S00_AXI_bresp, S01_AXI_bresp, aw_full}, 32'd0);
    chk("rst_state", {27'd0, outstanding, unexpected_b, push_ovf}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].p, vecs[i].m, vecs[i].bv, vecs[i].br, vecs[i].rdy);
      chk($sformatf("vec%0d_comb", i),
          {24'd0, Selected_Slave, S00_AXI_bvalid, S01_AXI_bvalid, S00_AXI_bresp, S01_AXI_bresp, aw_full},
          {24'd0, vecs[i].sel, vecs[i].s0v, vecs[i].s1v, vecs[i].s0r, vecs[i].s1r, vecs[i].full});
      @(posedge ACLK);
      #1;
      chk($sformatf("vec%0d_state", i), {27'd0, outstanding, unexpected_b, push_ovf},
          {27'd0, vecs[i].out, vecs[i].flags});
    end
    chk("sb_drained", sb_q.size(), 32'd0);

`ifdef BRESP_ERR_CNT_EN
    chk("err_cnt_two", {24'd0, err_cnt}, 32'd2);
    drive(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 1, 2'b10, 1);
    drive(0, 0, 1, 2'b10, 1);
    @(posedge ACLK);
    #1;
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    // Reset in the middle of traffic with B still asserted
    drive(1, 1, 0, 2'b00, 0);
    drive(1, 0, 0, 2'b00, 0);
    @(posedge ACLK);
    #1;
    chk("pre_rst_out", {29'd0, outstanding}, 32'd2);
    @(negedge ACLK);
    M_AXI_bvalid = 1'b1; M_AXI_bready = 1'b0; aw_push = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_comb", {26'd0, Selected_Slave, S00_AXI_bvalid, S01_AXI_bvalid, aw_full, unexpected_b, push_ovf}, 32'd0);
    chk("mid_rst_out", {29'd0, outstanding}, 32'd0);
`ifdef BRESP_ERR_CNT_EN
    chk("mid_rst_err", {24'd0, err_cnt}, 32'd0);
`endif
    sb_q.delete();
    @(negedge ACLK);
    M_AXI_bvalid = 1'b0;
    ARESET = 1'b0;

    // Ownership lost on reset: a fresh push routes cleanly
    drive(1, 1, 0, 2'b00, 0);
    drive(0, 0, 1, 2'b01, 1);
    chk("post_rst_route", {29'd0, Selected_Slave, S01_AXI_bvalid, S00_AXI_bvalid}, 32'd6);
    @(posedge ACLK);
    #1;
    chk("post_rst_state", {27'd0, outstanding, unexpected_b, push_ovf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
